// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one signed multiplier between two requesters; MULT_ARB_ZERO_BYPASS_EN enables the zero-operand bypass.
// Accept-to-response LAT+2 cycles (1 on bypass); ready only in IDLE, response strobe cannot be stalled.
module mult_arbiter #(
    parameter int WIDTH = 5,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 resp0_valid,
    output logic [2*WIDTH-1:0]   resp0_p,
    output logic                 resp1_valid,
    output logic [2*WIDTH-1:0]   resp1_p,
    output logic [WIDTH-1:0]     mul_mcand,
    output logic [WIDTH-1:0]     mul_mplier,
    output logic                 mul_start,
    input  logic [2*WIDTH-1:0]   mul_product
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               tag_q, tag_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] p0_q, p0_d;
    logic [2*WIDTH-1:0] p1_q, p1_d;

    logic               grant;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               zero_op;

    // A lone requester wins outright; on a tie the one not served last wins.
    assign grant  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign accept = !rst && (state_q == IDLE) && (req0_valid || req1_valid);
    assign sel_a  = grant ? req1_a : req0_a;
    assign sel_b  = grant ? req1_b : req0_b;

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign zero_op = (sel_a == '0) || (sel_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mcand_d      = sel_a;
                    mplier_d     = sel_b;
                    tag_d        = grant;
                    last_grant_d = grant;
                    if (zero_op) begin
                        state_d = DONE;
                        if (grant) p1_d = '0;
                        else       p0_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = CW'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (tag_q) p1_d = mul_product;
                    else       p0_d = mul_product;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            tag_q        <= 1'b0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
        end
    end

    // Strobes are gated by rst so they read zero for the whole reset interval.
    assign req0_ready  = accept && !grant;
    assign req1_ready  = accept && grant;
    assign mul_start   = !rst && (state_q == ISSUE);
    assign resp0_valid = !rst && (state_q == DONE) && !tag_q;
    assign resp1_valid = !rst && (state_q == DONE) && tag_q;
    assign resp0_p     = p0_q;
    assign resp1_p     = p1_q;
    assign mul_mcand   = mcand_q;
    assign mul_mplier  = mplier_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized scoreboard bench for mult_arbiter with an external multiplier model of fixed latency.
module tb_mult_arbiter;

    localparam int W   = 5;
    localparam int PW  = 2 * W;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic          resp0_valid, resp1_valid;
    logic [PW-1:0] resp0_p, resp1_p;
    logic [W-1:0]  mul_mcand, mul_mplier;
    logic          mul_start;
    logic [PW-1:0] mul_product;

    mult_arbiter #(.WIDTH(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_p(resp0_p),
        .resp1_valid(resp1_valid), .resp1_p(resp1_p),
        .mul_mcand(mul_mcand), .mul_mplier(mul_mplier), .mul_start(mul_start),
        .mul_product(mul_product)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        return PW'(ia * ib);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Shared multiplier: product only valid exactly LAT cycles after the start cycle.
    logic [PW-1:0] pend_q = '0, junk_q = '0;
    int            mcnt_q = 0;
    always @(posedge clk) begin
        junk_q <= PW'($urandom);
        if (mul_start) begin
            pend_q <= smul(mul_mcand, mul_mplier);
            mcnt_q <= LAT;
        end else if (mcnt_q > 0) begin
            mcnt_q <= mcnt_q - 1;
        end
    end
    assign mul_product = (mcnt_q == 1) ? pend_q : junk_q;

    // Stimulus drivers: hold valid/operands until accepted.
    int            rem0 = 0, rem1 = 0, prob = 100;
    bit            fixed_ops = 1'b1;
    logic [W-1:0]  fa0 = '0, fb0 = '0, fa1 = '0, fb1 = '0;
    logic          f0 = 1'b0, f1 = 1'b0;

    always @(negedge clk) begin
        f0 <= req0_valid && req0_ready;
        f1 <= req1_valid && req1_ready;
    end

    function automatic logic [W-1:0] pick(input logic [W-1:0] fixed_v);
        if (fixed_ops) return fixed_v;
        if ($urandom_range(7) == 0) return '0;
        return W'($urandom);
    endfunction

    always @(posedge clk) begin
        #1;
        if (!req0_valid || f0) begin
            if (rem0 > 0 && $urandom_range(99) < prob) begin
                req0_valid = 1'b1; req0_a = pick(fa0); req0_b = pick(fb0); rem0--;
            end else begin
                req0_valid = 1'b0;
            end
        end
        if (!req1_valid || f1) begin
            if (rem1 > 0 && $urandom_range(99) < prob) begin
                req1_valid = 1'b1; req1_a = pick(fa1); req1_b = pick(fb1); rem1--;
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    // Reference model + scoreboard: one operation in flight, timing from accept cycle.
    typedef struct {
        int            owner;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [PW-1:0] prod;
        int            start;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    int            next_free = 0;
    int            last_g = 1;
    int            g;
    bit            idle, exp_st, was_rst = 1'b0, zero;
    logic [PW-1:0] held0 = '0, held1 = '0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_strobes", {27'd0, req0_ready, req1_ready, mul_start, resp0_valid, resp1_valid}, 32'd0);
            exp_q.delete();
            next_free = cyc + 1;
            last_g    = 1;
            held0     = '0;
            held1     = '0;
            was_rst   = 1'b1;
        end else begin
            if (was_rst) begin
                chk("rst_mcand", 32'(mul_mcand), 32'd0);
                chk("rst_mplier", 32'(mul_mplier), 32'd0);
                was_rst = 1'b0;
            end
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                total++; bad++;
                $display("FAIL resp_missing cycle=%0d got=none expected_at=%0d", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (resp0_valid || resp1_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_unexpected cycle=%0d got=%0b%0b expected=none", cyc, resp1_valid, resp0_valid);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_cycle", cyc, e.due);
                    chk("resp_owner", {30'd0, resp1_valid, resp0_valid}, (e.owner == 1) ? 32'd2 : 32'd1);
                    if (e.owner == 1) held1 = e.prod;
                    else              held0 = e.prod;
                end
            end
            chk("resp0_p", 32'(resp0_p), 32'(held0));
            chk("resp1_p", 32'(resp1_p), 32'(held1));

            exp_st = (exp_q.size() > 0) && (exp_q[0].start == cyc);
            chk("mul_start", 32'(mul_start), 32'(exp_st));
            if (exp_st) begin
                chk("mul_mcand", 32'(mul_mcand), 32'(exp_q[0].a));
                chk("mul_mplier", 32'(mul_mplier), 32'(exp_q[0].b));
            end

            idle = (cyc >= next_free);
            if (req0_valid && !req1_valid)      g = 0;
            else if (req1_valid && !req0_valid) g = 1;
            else if (req0_valid && req1_valid)  g = 1 - last_g;
            else                                g = -1;
            chk("req0_ready", 32'(req0_ready), 32'(idle && g == 0));
            chk("req1_ready", 32'(req1_ready), 32'(idle && g == 1));
            if (idle && g >= 0) begin
                e.owner = g;
                e.a     = (g == 1) ? req1_a : req0_a;
                e.b     = (g == 1) ? req1_b : req0_b;
                e.prod  = smul(e.a, e.b);
`ifdef MULT_ARB_ZERO_BYPASS_EN
                zero = (e.a == '0) || (e.b == '0);
`else
                zero = 1'b0;
`endif
                e.start   = zero ? -1 : cyc + 1;
                e.due     = zero ? cyc + 1 : cyc + LAT + 2;
                next_free = e.due + 1;
                last_g    = g;
                exp_q.push_back(e);
            end
        end
    end

    task automatic wait_done(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (rem0 == 0) && (rem1 == 0) && !req0_valid && !req1_valid &&
                   (exp_q.size() == 0) && (cyc >= next_free);
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    initial begin
        bit seen;
        // Reset with both valid high, then strict alternation (11,-3) vs (-10,-11).
        fa0 = 5'b01011; fb0 = 5'b11101; fa1 = 5'b10110; fb1 = 5'b10101;
        req0_a = fa0; req0_b = fb0; req1_a = fa1; req1_b = fb1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rem0 = 1; rem1 = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        wait_done(200);
        chk("alt_p0", 32'(resp0_p), 32'(10'b1111011111));
        chk("alt_p1", 32'(resp1_p), 32'(10'b0001101110));

        // req0 alone: -10 * 4.
        @(posedge clk); #2;
        fa0 = 5'b10110; fb0 = 5'b00100; rem0 = 1;
        wait_done(200);
        chk("single_p0", 32'(resp0_p), 32'(10'b1111011000));

        // Reset during WAIT of a req1 operation, then a tie must go to req0.
        @(posedge clk); #2;
        fa1 = 5'b01001; fb1 = 5'b00011; rem1 = 1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = mul_start;
        end
        chk("start_seen", 32'(seen), 32'd1);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        rem0 = 1; rem1 = 1;
        wait_done(200);

        // Persistent req1 alone.
        @(posedge clk); #2;
        rem1 = 3;
        wait_done(200);

        // Zero operand.
        @(posedge clk); #2;
        fa0 = 5'b00000; fb0 = 5'b01011; rem0 = 1;
        wait_done(200);
        chk("zero_p0", 32'(resp0_p), 32'd0);

        // Random traffic: sparse then saturated.
        @(posedge clk); #2;
        fixed_ops = 1'b0; prob = 50; rem0 = 40; rem1 = 40;
        wait_done(3000);
        @(posedge clk); #2;
        prob = 100; rem0 = 25; rem1 = 25;
        wait_done(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one signed multiplier datapath between two requesters. Each requester presents a pair of signed operands over a valid/ready handshake; the block latches the winning pair, pulses the multiplier's `start`, waits a fixed datapath latency, then returns the signed product to the owning requester as a one-cycle response. It sits between the operand sources and the single shared multiplier instance.

## Interface
- `WIDTH`, default 5: operand width in bits, two's complement.
- `LAT`, default 2: cycles from the `mul_start` cycle to a valid `mul_product`. Minimum 1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1  requester has operands.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  multiplicand and multiplier.
- `resp0_valid`, `resp1_valid`  out  1  one-cycle product strobe.
- `resp0_p`, `resp1_p`  out  2*WIDTH  signed product.
- `mul_mcand`, `mul_mplier`  out  WIDTH  operands to the shared multiplier.
- `mul_start`  out  1  one-cycle start pulse to the multiplier.
- `mul_product`  in  2*WIDTH  multiplier result.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester not granted last.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` = (state==IDLE) && grant==N. It is combinational and never high for both requesters.
  - On the handshake, latch a, b and the owner tag into `mul_mcand`/`mul_mplier`/`tag`, update `last_grant`, and go to ISSUE.
- ISSUE: `mul_start`=1 for exactly this cycle. Operands are stable from this cycle until DONE. Load `cnt`=LAT-1, then go to WAIT.
- WAIT: decrement `cnt`. On the edge where `cnt`==0, capture `mul_product` into the response register and go to DONE.
- DONE: `respN_valid`=1 for the owner only, with `respN_p` = captured product. Next state is IDLE.
- `respN_p` holds its value after DONE until the next response to that requester.
- There is no response backpressure; the requester must accept the strobe.
- The product is passed through unchanged: 2*WIDTH bits, sign in the MSB. The block performs no arithmetic on it except in the zero bypass.
- Requests arriving outside IDLE are held off (ready=0). The requester must keep valid and operands stable until ready.

## Timing
- Reset values:
  - All `ready`, `resp*_valid` and `mul_start` are 0.
  - `resp*_p`, `mul_mcand` and `mul_mplier` are 0.
  - State is IDLE and `last_grant`=1.
- Reset mid-operation (any state): the operation is abandoned with no response and no further `mul_start`. Reset wins over a simultaneous handshake.
- Handshake in cycle T: ISSUE at T+1, WAIT at T+2..T+1+LAT, DONE (response) at T+2+LAT, IDLE at T+3+LAT.
- A new handshake is possible at T+3+LAT, so throughput is one operation per LAT+3 cycles.
- With LAT=2: accept 0, start 1, response 4, next accept 5.
- Simultaneous valid on both requesters: they alternate strictly, with no starvation.
- A single persistent requester is granted back-to-back.

## Configuration
- `MULT_ARB_ZERO_BYPASS_EN` defined:
  - If the accepted a==0 or b==0, the FSM goes IDLE→DONE directly with product 0.
  - `mul_start` is not pulsed, and the response arrives at T+1.
- Undefined: zero operands take the normal path and latency.

## Test plan
- Reset: hold `rst` for 2 cycles with both valids high. Required: all outputs 0, no ready, and the first grant after release goes to req0.
- req0 alone, a=5'b10110 (-10), b=5'b00100 (4), LAT=2, bench multiplier model returns -40. Required:
  - `mul_start` pulses in cycle 1 only.
  - `resp0_valid` is high in cycle 4 with `resp0_p`=10'b1111011000.
  - `req0_ready` is 0 in cycles 1–4.
- Both valid continuously, req0 (11,-3) and req1 (-10,-11). Required:
  - Grants alternate 0,1,0,1.
  - `resp0_p`=10'b1111011111 (-33) and `resp1_p`=10'b0001101110 (110).
  - Accepts occur at cycles 0, 5, 10.
- `rst` pulsed during WAIT of a req1 operation. Required: no `resp1_valid`, `mul_start` stays 0, and the next tie is granted to req0.
- req1 only, issued 3 times. Required: three back-to-back grants to req1, `resp0_valid` never asserts, accept spacing is 5 cycles.
- req0 a=0, b=5'b01011. Required:
  - With `MULT_ARB_ZERO_BYPASS_EN`: response at cycle 1 with value 0 and no `mul_start`.
  - Without it: response at cycle 4 with value 0.
